// File: rtl/mem_arb_pkg.sv
// Shared state encoding and default sizing for the unified memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } arb_state_t;

    localparam int DEF_ADDR_W     = 64;
    localparam int DEF_DATA_W     = 64;
    localparam int DEF_MAX_STREAK = 4;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of data grants made while a fetch was waiting; cleared by a fetch grant.
module arb_starve_counter
    import mem_arb_pkg::*;
#(
    parameter int MAX_STREAK = DEF_MAX_STREAK
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int CNT_W = $clog2(MAX_STREAK + 1);

    logic [CNT_W-1:0] count;

    assign at_max = (count == CNT_W'(MAX_STREAK));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one memory port, data first.
// Define ARB_STARVE_GUARD_EN to let a waiting fetch win after MAX_STREAK data grants.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MAX_STREAK = DEF_MAX_STREAK
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    if (MAX_STREAK < 1) begin : g_bad_streak
        $error("unified_mem_arbiter: MAX_STREAK must be at least 1");
    end

    arb_state_t        state, state_next;
    logic              grant_if, grant_dm;
    logic              ack_cycle;
    logic              if_first;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic              if_ack_q, dm_ack_q;
    logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;

    // A requester still holds req during its ack cycle, so no grant is made then.
    assign ack_cycle = if_ack_q | dm_ack_q;

`ifdef ARB_STARVE_GUARD_EN
    arb_starve_counter #(
        .MAX_STREAK(MAX_STREAK)
    ) u_starve_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (grant_dm & if_req),
        .clr   (grant_if),
        .at_max(if_first)
    );
`else
    assign if_first = 1'b0;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        grant_if   = 1'b0;
        grant_dm   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!ack_cycle) begin
                    if (dm_req && !(if_req && if_first)) begin
                        grant_dm = 1'b1;
                    end else if (if_req) begin
                        grant_if = 1'b1;
                    end
                end
                if (grant_dm) begin
                    state_next = DM_BUSY;
                end else if (grant_if) begin
                    state_next = IF_BUSY;
                end
            end
            IF_BUSY, DM_BUSY: begin
                if (mem_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_ack_q   <= 1'b0;
            dm_ack_q   <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state    <= state_next;
            if_ack_q <= (state == IF_BUSY) && mem_ready;
            dm_ack_q <= (state == DM_BUSY) && mem_ready;
            if (grant_dm) begin
                addr_q  <= dm_addr;
                we_q    <= dm_we;
                wdata_q <= dm_wdata;
            end else if (grant_if) begin
                addr_q  <= if_addr;
                we_q    <= 1'b0;
                wdata_q <= '0;
            end
            if ((state == IF_BUSY) && mem_ready) begin
                if_rdata_q <= mem_rdata;
            end
            if ((state == DM_BUSY) && mem_ready) begin
                dm_rdata_q <= mem_rdata;
            end
        end
    end

    assign mem_req   = (state != IDLE);
    assign mem_we    = we_q && (state == DM_BUSY);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_ack    = if_ack_q;
    assign dm_ack    = dm_ack_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed scenarios plus random traffic vs. a transaction model.
`timescale 1ns/1ps
module tb_unified_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = DEF_ADDR_W;
    localparam int DW = DEF_DATA_W;
    localparam int MS = DEF_MAX_STREAK;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, dm_req, dm_we, mem_ready;
    logic [AW-1:0] if_addr, dm_addr;
    logic [DW-1:0] dm_wdata, mem_rdata;
    logic          if_ack, dm_ack, mem_req, mem_we;
    logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_STREAK(MS)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Transaction-level reference: who owns memory, what was latched, pending acks.
    int            m_owner;      // 0 none, 1 fetch, 2 data
    bit            m_if_ack, m_dm_ack, m_we;
    int            m_streak;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_if_rdata, m_dm_rdata;

    task automatic model_reset();
        m_owner = 0; m_if_ack = 0; m_dm_ack = 0; m_we = 0; m_streak = 0;
        m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_dm_rdata = '0;
    endtask

    task automatic model_edge();
        bit was_ack, if_wins;
        if (!reset) begin
            model_reset();
            return;
        end
        was_ack  = m_if_ack || m_dm_ack;
        m_if_ack = 0;
        m_dm_ack = 0;
        if (m_owner != 0) begin
            if (mem_ready) begin
                if (m_owner == 1) begin m_if_ack = 1; m_if_rdata = mem_rdata; end
                else              begin m_dm_ack = 1; m_dm_rdata = mem_rdata; end
                m_owner = 0;
            end
        end else if (!was_ack && (if_req || dm_req)) begin
            if_wins = if_req && (!dm_req || (GUARD && m_streak == MS));
            if (if_wins) begin
                m_owner = 1; m_addr = if_addr; m_we = 0; m_streak = 0;
            end else begin
                m_owner = 2; m_addr = dm_addr; m_we = dm_we; m_wdata = dm_wdata;
                if (GUARD && if_req && m_streak < MS) m_streak++;
            end
        end
    endtask

    task automatic compare_all();
        check("mem_req",  mem_req,  m_owner != 0);
        check("mem_we",   mem_we,   (m_owner == 2) && m_we);
        check("mem_addr", mem_addr, m_addr);
        if (m_owner == 2) check("mem_wdata", mem_wdata, m_wdata);
        check("if_ack",   if_ack,   m_if_ack);
        check("dm_ack",   dm_ack,   m_dm_ack);
        check("if_rdata", if_rdata, m_if_rdata);
        check("dm_rdata", dm_rdata, m_dm_rdata);
    endtask

    logic [AW-1:0] grant_q[$];
    logic          prev_req = 1'b0;

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        if (mem_req && !prev_req) grant_q.push_back(mem_addr);
        prev_req = mem_req;
    endtask

    initial begin
        logic [AW-1:0] exp_addr;
        reset = 1'b0; if_req = 0; dm_req = 0; dm_we = 0; mem_ready = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
        model_reset();

        // Reset state
        tick(); tick();
        check("rst_mem_req", mem_req, 0);
        check("rst_acks", {if_ack, dm_ack}, 0);
        check("rst_mem_addr", mem_addr, 0);

        // Fetch read right after reset release, memory always ready
        reset = 1'b1; if_req = 1; if_addr = 64'h40; mem_ready = 1;
        mem_rdata = 64'h1234_5678_9ABC_DEF0;
        tick();
        check("fetch_mem_req", mem_req, 1);
        check("fetch_mem_addr", mem_addr, 64'h40);
        tick();
        check("fetch_ack", if_ack, 1);
        check("fetch_rdata", if_rdata, 64'h1234_5678_9ABC_DEF0);
        check("fetch_mem_req_done", mem_req, 0);
        if_req = 0;
        tick();
        check("fetch_ack_pulse", if_ack, 0);

        // Simultaneous requests: data write wins, fetch follows after the idle gap
        if_req = 1; if_addr = 64'h80;
        dm_req = 1; dm_we = 1; dm_addr = 64'h100; dm_wdata = 64'hDEAD;
        tick();
        check("both_dm_first_addr", mem_addr, 64'h100);
        check("both_dm_we", mem_we, 1);
        check("both_dm_wdata", mem_wdata, 64'hDEAD);
        tick();
        check("both_dm_ack", dm_ack, 1);
        check("both_ack_cycle_idle", mem_req, 0);
        dm_req = 0; dm_we = 0;
        tick();
        check("both_gap_idle", mem_req, 0);
        tick();
        check("both_if_addr", mem_addr, 64'h80);
        check("both_if_we", mem_we, 0);
        tick();
        check("both_if_ack", if_ack, 1);
        if_req = 0;
        tick();

        // Slow memory: held for five cycles
        dm_req = 1; dm_addr = 64'h300; mem_ready = 0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("slow_mem_req", mem_req, 1);
            check("slow_mem_addr", mem_addr, 64'h300);
            check("slow_no_ack", dm_ack, 0);
        end
        mem_ready = 1; mem_rdata = 64'hCAFE_F00D;
        tick();
        check("slow_ack", dm_ack, 1);
        check("slow_rdata", dm_rdata, 64'hCAFE_F00D);
        dm_req = 0;
        tick();

        // Requester drops req after grant: transaction still completes once
        dm_req = 1; dm_addr = 64'h500; mem_ready = 0;
        tick();
        check("drop_granted", mem_req, 1);
        dm_req = 0;
        tick();
        check("drop_still_busy", mem_req, 1);
        mem_ready = 1;
        tick();
        check("drop_ack", dm_ack, 1);
        tick();
        check("drop_ack_once", dm_ack, 0);

        // Reset during a data transaction
        dm_req = 1; dm_addr = 64'h700; mem_ready = 0;
        tick();
        check("rstmid_busy", mem_req, 1);
        #3 reset = 1'b0;
        #1;
        model_reset();
        check("rstmid_mem_req_async", mem_req, 0);
        mem_ready = 1;
        tick();
        check("rstmid_no_ack", dm_ack, 0);
        check("rstmid_idle", mem_req, 0);
        dm_req = 0;
        #4 reset = 1'b1;
        tick();
        check("rstmid_no_late_ack", dm_ack, 0);

        // Both held continuously: grant order depends on the starvation guard
        if_req = 1; if_addr = 64'h1000; dm_req = 1; dm_we = 0; dm_addr = 64'h2000; mem_ready = 1;
        grant_q.delete();
        repeat (40) tick();
        check("streak_grant_count", grant_q.size() >= 10, 1);
        for (int k = 0; k < 10 && k < grant_q.size(); k++) begin
            exp_addr = (GUARD && (k % 5 == 4)) ? 64'h1000 : 64'h2000;
            check($sformatf("streak_grant_%0d", k), grant_q[k], exp_addr);
        end
        if_req = 0; dm_req = 0;
        repeat (4) tick();

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            if (if_req && if_ack) if_req = 0;
            else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = {$urandom, $urandom};
            end
            if (dm_req && dm_ack) dm_req = 0;
            else if (!dm_req && $urandom_range(0, 2) == 0) begin
                dm_req = 1; dm_we = 1'($urandom_range(0, 1));
                dm_addr = {$urandom, $urandom}; dm_wdata = {$urandom, $urandom};
            end
            mem_ready = ($urandom_range(0, 2) != 0);
            mem_rdata = {$urandom, $urandom};
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
